div_recip_iter: RTL and testbench

//  Iterative Goldschmidt mantissa divider: q = a/b, a and b normalized 1.23 mantissas in [1,2).

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_mul_trunc.sv | 13 +
 rtl/div_recip_iter.sv | 175 +++++++++++++++++
 tb/tb_div_recip_iter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the Goldschmidt mantissa divider.
package div_pkg;

    localparam int unsigned WF_DEF    = 30;
    localparam int unsigned ITERS_DEF = 3;
    localparam int unsigned LUT_IDX_W = 5;
    localparam int unsigned LUT_VAL_W = 24;

    // Q2.(WF_DEF-2) constants
    localparam logic [WF_DEF-1:0] ONE_Q = {2'b01, {(WF_DEF-2){1'b0}}};
    localparam logic [WF_DEF-1:0] TWO_Q = {2'b10, {(WF_DEF-2){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_SCL_N,
        S_SCL_D,
        S_IT_N,
        S_IT_D,
        S_NORM,
        S_DONE
    } div_state_e;

endpackage

// File: rtl/div_mul_trunc.sv
// Combinational Q2.(WF-2) x Q2.(WF-2) multiplier; product truncated back to Q2.(WF-2).
module div_mul_trunc #(
    parameter int unsigned WF = 30
) (
    input  logic [WF-1:0] a_i,
    input  logic [WF-1:0] b_i,
    output logic [WF-1:0] p_o
);

    // Q4.(2WF-4) product: drop WF-2 fraction bits and the two top integer bits
    assign p_o = WF'(((2*WF)'(a_i) * (2*WF)'(b_i)) >> (WF - 2));

endmodule

// File: rtl/div_recip_iter.sv
// Iterative Goldschmidt divider for 1.23 mantissas, seeded by an external reciprocal table.
// Optional build macro DIV_ROUND_EN: round-to-nearest (half-ulp add) in NORM instead of truncation.
module div_recip_iter
    import div_pkg::*;
#(
    parameter int unsigned WF    = WF_DEF,
    parameter int unsigned ITERS = ITERS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [23:0]          in_a,
    input  logic [23:0]          in_b,
    output logic [LUT_IDX_W-1:0] lut_index,
    input  logic [LUT_VAL_W-1:0] lut_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [23:0]          out_q,
    output logic                 out_lt
);

    localparam int unsigned    IW      = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [IW-1:0]  LAST_IT = IW'(ITERS - 1);
    localparam logic [WF-1:0]  TWO_L   = {2'b10, {(WF-2){1'b0}}};

    div_state_e    state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic [23:0]   a_q, a_d, b_q, b_d;
    logic [WF-1:0] r_q, r_d, n_q, n_d, d_q, d_d, f_q, f_d;
    logic [IW-1:0] it_q, it_d;
    logic [23:0]   quo_q, quo_d;
    logic          lt_q, lt_d;
    logic [WF-1:0] mul_x, mul_y, mul_p;
    logic [WF-1:0] a_ext, b_ext;
    logic          accept;

    assign accept    = in_valid && in_ready_q;
    assign a_ext     = {1'b0, a_q, {(WF-25){1'b0}}};
    assign b_ext     = {1'b0, b_q, {(WF-25){1'b0}}};
    assign lut_index = b_q[22:18];
    assign in_ready  = in_ready_q;
    assign out_q     = quo_q;
    assign out_lt    = lt_q;

    div_mul_trunc #(.WF(WF)) u_mul (
        .a_i (mul_x),
        .b_i (mul_y),
        .p_o (mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SEED;
            S_SEED:  state_d = S_SCL_N;
            S_SCL_N: state_d = S_SCL_D;
            S_SCL_D: state_d = S_IT_N;
            S_IT_N:  state_d = S_IT_D;
            S_IT_D:  state_d = (it_q == LAST_IT) ? S_NORM : S_IT_N;
            S_NORM:  state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // in_ready is registered so it stays low through reset and rises one edge after release
    always_comb begin
        in_ready_d = (state_d == S_IDLE);
        out_valid  = (state_q == S_DONE);
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        r_d   = r_q;
        n_d   = n_q;
        d_d   = d_q;
        f_d   = f_q;
        it_d  = it_q;
        quo_d = quo_q;
        lt_d  = lt_q;
        mul_x = '0;
        mul_y = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d = in_a;
                    b_d = in_b;
                end
            end
            S_SEED:  r_d = {2'b00, lut_value, {(WF-2-LUT_VAL_W){1'b0}}};
            S_SCL_N: begin
                mul_x = a_ext;
                mul_y = r_q;
                n_d   = mul_p;
            end
            S_SCL_D: begin
                mul_x = b_ext;
                mul_y = r_q;
                d_d   = mul_p;
            end
            S_IT_N: begin
                f_d   = TWO_L - d_q;
                mul_x = n_q;
                mul_y = f_d;
                n_d   = mul_p;
            end
            S_IT_D: begin
                mul_x = d_q;
                mul_y = f_q;
                d_d   = mul_p;
                it_d  = (it_q == LAST_IT) ? '0 : it_q + 1'b1;
            end
            S_NORM:  {lt_d, quo_d} = norm_result(n_q);
            default: ;
        endcase
    end

    // Quotient lies in [0.5,2); the lt path takes one extra fraction bit
    function automatic logic [24:0] norm_result(input logic [WF-1:0] n);
        logic [24:0] hi_sum, lo_sum;
        logic [24:0] res;
`ifdef DIV_ROUND_EN
        hi_sum = {1'b0, n[WF-2 -: 24]} + {24'd0, n[WF-26]};
        lo_sum = {1'b0, n[WF-3 -: 24]} + {24'd0, n[WF-27]};
        if (n[WF-2])
            res = {1'b0, hi_sum[24] ? 24'hFFFFFF : hi_sum[23:0]};
        else if (lo_sum[24])
            res = {1'b0, 24'h800000};
        else
            res = {1'b1, lo_sum[23:0]};
`else
        hi_sum = {1'b0, n[WF-2 -: 24]};
        lo_sum = {1'b1, n[WF-3 -: 24]};
        res    = n[WF-2] ? hi_sum : lo_sum;
`endif
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            n_q   <= '0;
            d_q   <= '0;
            f_q   <= '0;
            it_q  <= '0;
            quo_q <= '0;
            lt_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            r_q   <= r_d;
            n_q   <= n_d;
            d_q   <= d_d;
            f_q   <= f_d;
            it_q  <= it_d;
            quo_q <= quo_d;
            lt_q  <= lt_d;
        end
    end

endmodule

// File: tb/tb_div_recip_iter.sv
// Scoreboard bench for div_recip_iter: directed vectors, handshake/reset cases, random sweep.
module tb_div_recip_iter;

`ifdef DIV_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_lt;
    logic [23:0] in_a, in_b, lut_value, out_q;
    logic [4:0]  lut_index;

    always #5 clk = ~clk;

    div_recip_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .lut_index (lut_index),
        .lut_value (lut_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_lt    (out_lt)
    );

    // Reciprocal table: round(2^24 / (1 + (idx+1)/32))
    function automatic logic [23:0] lut_fn(input logic [4:0] idx);
        longint unsigned d;
        d = 64'd33 + 64'(idx);
        return 24'(((64'd1 << 29) + d / 2) / d);
    endfunction

    assign lut_value = lut_fn(lut_index);

    typedef struct {
        logic [23:0] a, b, q0, q1;
        logic        lt0, lt1;
        int          kind;   // 0 directed, 1 error-bound model, 2 value undefined
    } exp_t;

    exp_t  sb[$];
    string nm_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string nm, input bit ok, input longint act, input longint req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic push(input string nm, input logic [23:0] a, input logic [23:0] b, input int kind,
                        input logic [23:0] q0, input logic lt0, input logic [23:0] qt, input logic ltt);
        exp_t e;
        e.a = a; e.b = b; e.kind = kind;
        e.q0 = q0; e.lt0 = lt0;
        e.q1 = RND ? q0 : qt;
        e.lt1 = RND ? lt0 : ltt;
        sb.push_back(e);
        nm_q.push_back(nm);
    endtask

    exp_t        me;
    string       mnm;
    int unsigned msh;
    longint      mdiff;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 1'b0, {out_lt, out_q}, 0);
            end else begin
                me  = sb.pop_front();
                mnm = nm_q.pop_front();
                if (me.kind == 0) begin
                    chk(mnm, (out_q == me.q0 && out_lt == me.lt0) || (out_q == me.q1 && out_lt == me.lt1),
                        {out_lt, out_q}, {me.lt0, me.q0});
                end else if (me.kind == 1) begin
                    msh   = out_lt ? 24 : 23;
                    mdiff = longint'(out_q) * longint'(me.b) - (longint'(me.a) <<< msh);
                    if (mdiff < 0) mdiff = -mdiff;
                    chk({mnm, "_err"}, RND ? (4 * mdiff <= 3 * longint'(me.b)) : (4 * mdiff <= 5 * longint'(me.b)),
                        {out_lt, out_q}, (longint'(me.a) <<< msh) / longint'(me.b));
                    chk({mnm, "_norm"}, out_q[23] == 1'b1, out_q, 24'h800000);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] a, input logic [23:0] b);
        int n;
        in_a = a; in_b = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 1'b0, n, 0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [23:0] ra, rb;
        logic [23:0] hq0, hq1;
        hq0 = 24'hAAAAAB;
        hq1 = RND ? 24'hAAAAAB : 24'hAAAAAA;
        in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready == 1'b0, in_ready, 0);
        chk("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("rst_out_q", out_q == 24'h0, out_q, 0);
        chk("rst_out_lt", out_lt == 1'b0, out_lt, 0);
        chk("rst_lut_index", lut_index == 5'd0, lut_index, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("in_ready_before_edge", in_ready == 1'b0, in_ready, 0);
        tick();
        chk("in_ready_after_edge", in_ready == 1'b1, in_ready, 1);

        push("a_eq_b", 24'h800000, 24'h800000, 0, 24'h800000, 1'b0, 24'hFFFFFF, 1'b1);
        send(24'h800000, 24'h800000);

        push("one_and_half", 24'hC00000, 24'h800000, 0, 24'hC00000, 1'b0, 24'hBFFFFF, 1'b0);
        send(24'hC00000, 24'h800000);
        chk("lut_index_b800000", lut_index == 5'd0, lut_index, 0);
        wait_out(lat);
        chk("latency", lat == 10, lat, 10);

        push("two_thirds", 24'h800000, 24'hC00000, 0, 24'hAAAAAB, 1'b1, 24'hAAAAAA, 1'b1);
        send(24'h800000, 24'hC00000);
        chk("lut_index_bC00000", lut_index == 5'd16, lut_index, 16);

        push("near_two", 24'hFFFFFF, 24'h800001, 0, 24'hFFFFFD, 1'b0, 24'hFFFFFC, 1'b0);
        send(24'hFFFFFF, 24'h800001);
        push("max_q", 24'hFFFFFF, 24'h800000, 0, 24'hFFFFFF, 1'b0, 24'hFFFFFE, 1'b0);
        send(24'hFFFFFF, 24'h800000);

        push("unnorm", 24'h400000, 24'h800000, 2, 24'h0, 1'b0, 24'h0, 1'b0);
        send(24'h400000, 24'h800000);
        wait_out(lat);
        chk("unnorm_latency", lat == 10, lat, 10);

        // Consumer stall: result must hold and new operands must be ignored
        wait (in_ready == 1'b1);
        #1;
        out_ready = 1'b0;
        push("stall_result", 24'h800000, 24'hC00000, 0, hq0, 1'b1, hq1, 1'b1);
        send(24'h800000, 24'hC00000);
        wait_out(lat);
        chk("stall_latency", lat == 10, lat, 10);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_a = 24'hC00000; in_b = 24'h800000; in_valid = 1'b1;
            end
            if (i == 2) in_valid = 1'b0;
            tick();
            chk("stall_out_valid", out_valid == 1'b1, out_valid, 1);
            chk("stall_in_ready", in_ready == 1'b0, in_ready, 0);
            chk("stall_out_q", (out_q == hq0 || out_q == hq1) && out_lt == 1'b1, {out_lt, out_q}, {1'b1, hq0});
        end
        out_ready = 1'b1;
        tick();
        chk("in_ready_after_hs", in_ready == 1'b1, in_ready, 1);
        chk("out_valid_after_hs", out_valid == 1'b0, out_valid, 0);

        // Abort during the first IT_N pass
        send(24'hC00000, 24'h900000);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_itn_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("abort_itn_in_ready", in_ready == 1'b0, in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("abort_itn_recover", in_ready == 1'b1, in_ready, 1);

        // Abort while a result is held in DONE
        out_ready = 1'b0;
        send(24'hC00000, 24'h800000);
        wait_out(lat);
        chk("abort_done_latency", lat == 10, lat, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_done_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("abort_done_out_q", out_q == 24'h0 && out_lt == 1'b0, {out_lt, out_q}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("abort_done_recover", in_ready == 1'b1, in_ready, 1);

        for (int i = 0; i < 1000; i++) begin
            ra = {1'b1, 23'($urandom)};
            rb = {1'b1, 23'($urandom)};
            push("rand", ra, rb, 1, 24'h0, 1'b0, 24'h0, 1'b0);
            send(ra, rb);
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        chk("drain", sb.size() == 0, sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
